nn_convnode_backprop: RTL and testbench
=======================================

# nn_convnode_backprop

Backward-pass counterpart of the stochastic convolution node. It takes the signed error streams from the N downstream nodes fed by this node's window, weights each by its forward-path weight stream, and collapses them into one signed error stream through a saturating difference counter. The output is gated by the local activation-derivative stream `zp`. The block sits in the backprop chain between the downstream layer's error outputs and this layer's weight-update and upstream-error logic. A three-state phase FSM drains the residual count when the backprop phase ends.

## Interface
Parameters:
- `N`, 4: window size, i.e. the number of downstream error inputs.
- `DIFFCOUNTER_SIZE`, 4: width W of the signed difference counter. Must be ≥ clog2(N+1)+1.
- `DIFFCOUNT_LOWERLIM`, 1: minimum magnitude L that triggers an output pulse. Must satisfy 1 ≤ L ≤ 2^(W-1)-1.

Ports:
- `CLK`  in  1: clock. One clock domain; all state changes on the rising edge.
- `INIT`  in  1: reset, asynchronous, active-high.
- `BP_EN`  in  1: backprop phase enable, level.
- `delta_in`  in  N: downstream error bitstreams.
- `SIGN_delta`  in  N: sign per error stream; 1 = negative.
- `alpha`  in  N: forward weight bitstreams.
- `SIGN_alpha`  in  N: weight signs.
- `zp`  in  1: activation-derivative bitstream.
- `delta_out`  out  1: output error bitstream, registered.
- `SIGN_delta_out`  out  1: output error sign, registered.
- `BP_DONE`  out  1: one-cycle pulse when the drain completes.

## Operation
- Per input n:
  - product `p_n = delta_in[n] & alpha[n]`
  - sign `s_n = SIGN_delta[n] ^ SIGN_alpha[n]`
- Counts:
  - `pos` = number of n with p_n=1 and s_n=0.
  - `neg` = number of n with p_n=1 and s_n=1.
  - Both counts are forced to 0 unless state = RUN and BP_EN = 1.
- Signed counter D, W bits, range [-2^(W-1), 2^(W-1)-1]. Each cycle in RUN or DRAIN:
  - S = D + pos − neg, computed at W+1 bits.
  - If S ≥ L: emit with sign 0; D ← sat(S−1).
  - Else if S ≤ −L: emit with sign 1; D ← sat(S+1).
  - Else: no emit; D ← sat(S).
- Outputs:
  - `delta_out` ← emit & zp.
  - `SIGN_delta_out` ← emit sign when emit=1; otherwise it holds its value.
  - The sign updates even when zp=0. A zp=0 cycle still consumes the count.
- FSM states are IDLE, RUN and DRAIN:
  - IDLE: D forced to 0; `delta_out` = 0; no processing. BP_EN=1 → RUN. Inputs in the transition cycle are ignored.
  - RUN: process inputs. BP_EN=0 → DRAIN. The transition cycle is processed with pos=neg=0, but the emission rule still applies.
  - DRAIN: pos=neg=0; emission rule applies.
    - BP_EN=1 → RUN, with D preserved. This takes priority over completion.
    - Else, a cycle with no emit → IDLE, and `BP_DONE` is high for exactly the next cycle.
- Saturation clips silently; no overflow flag.

## Timing
- Latency: inputs in cycle t appear on `delta_out` after the edge ending cycle t, i.e. 1 cycle.
- `BP_DONE` is registered. It is high in the first cycle of IDLE after a completed drain, never otherwise.
- Drain length from residual D = k, with BP_EN=0 and L=1: |k| emission cycles, then one no-emit cycle, then `BP_DONE`.
- `INIT` asserted at any time, including mid-RUN or mid-DRAIN, immediately sets:
  - state = IDLE, D = 0
  - `delta_out` = 0, `SIGN_delta_out` = 0, `BP_DONE` = 0
- No drain or done pulse follows a reset.
- BP_EN toggling every cycle is legal; the FSM alternates RUN and DRAIN per the rules above.

## Structure
- Shared package holds:
  - the state enum (IDLE, RUN, DRAIN)
  - a width helper for the counter
  - a parameter-legality check constant
- The natural sub-module is `nn_sdiff_counter`. It contains:
  - signed accumulate
  - threshold emission
  - saturation
  - a synchronous clear input

  The FSM, popcount and zp gating stay in the top module.

## Test plan
All scenarios use N=4, W=4 (range −8..7), L=1.
1. Positive saturation: BP_EN=1, delta_in=alpha=4'hF, all signs 0, zp=1 for 3 RUN cycles → D goes 3, 6, 7 (9 clipped to 7); `delta_out`=1 and `SIGN_delta_out`=0 each cycle.
2. Negative: delta_in=alpha=4'b0011, SIGN_alpha=4'b0011, other signs 0 → S=−2, D=−1, then D=−2…; `delta_out`=1, `SIGN_delta_out`=1.
3. Cancellation: all products 1, SIGN_delta=4'b0101, alpha signs 0 → pos=neg=2, no emit from D=0; `delta_out`=0; sign holds its prior value.
4. Drain: from D=7, drop BP_EN → 7 cycles of `delta_out`=1, then 1 cycle of 0, then `BP_DONE`=1 for one cycle; state IDLE.
5. Derivative gating: scenario 1 with zp=0 → `delta_out`=0 throughout, D still reaches 7, and the drain still takes 7 emit cycles.
6. Reset mid-drain: assert INIT at D=4 in DRAIN → all outputs 0 in the same cycle (asynchronous); no `BP_DONE` afterwards; BP_EN=1 restarts from D=0.

Source files
------------

// File: rtl/nn_convnode_backprop_pkg.sv
// Shared definitions for the stochastic convolution-node backprop path:
// phase FSM encoding, counter width helper and parameter legality check.
package nn_convnode_backprop_pkg;

  // Phase states of the backprop node.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } bp_state_e;

  // Plain constants for the state register, kept for legacy tooling.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Bits needed to hold a popcount of n one-bit products (0..n).
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // True when the window size, counter width and emission threshold fit together.
  function automatic bit params_ok(input int n, input int w, input int l);
    return (n >= 1) && (w >= cnt_width(n) + 1) && (w < 31) &&
           (l >= 1) && (l <= (1 << (w - 1)) - 1);
  endfunction

endpackage

// File: rtl/nn_sdiff_counter.sv
// Signed saturating difference counter: accumulates pos-neg each cycle,
// emits a signed pulse whenever the running sum reaches the threshold and
// pays one unit of count back for every pulse.
module nn_sdiff_counter
  import nn_convnode_backprop_pkg::*;
#(
  parameter int W   = 4,
  parameter int CW  = 3,
  parameter int LIM = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clear,
  input  logic          i_en,
  input  logic [CW-1:0] i_pos,
  input  logic [CW-1:0] i_neg,
  output logic          o_emit,
  output logic          o_emitSign
);

  // One extra bit so that count + pos - neg never wraps before saturation.
  localparam int SW = W + 1;
  localparam logic signed [SW-1:0] P_MAX  = SW'((1 << (W - 1)) - 1);
  localparam logic signed [SW-1:0] P_MIN  = SW'(-(1 << (W - 1)));
  localparam logic signed [SW-1:0] P_LIM  = SW'(LIM);
  localparam logic signed [SW-1:0] P_NLIM = SW'(-LIM);
  localparam logic signed [SW-1:0] P_ONE  = SW'(1);

  logic signed [W-1:0]  r_count;
  logic signed [SW-1:0] w_sum;
  logic signed [SW-1:0] w_adj;
  logic        [W-1:0]  w_next;
  logic                 w_emitPos;
  logic                 w_emitNeg;

  assign w_sum     = $signed({r_count[W-1], r_count}) + $signed(SW'(i_pos)) - $signed(SW'(i_neg));
  assign w_emitPos = (w_sum >= P_LIM);
  assign w_emitNeg = (w_sum <= P_NLIM);

  assign o_emit     = i_en & (w_emitPos | w_emitNeg);
  assign o_emitSign = i_en & w_emitNeg;

  // Pay back one unit per emitted pulse, then clip into the W-bit signed range.
  always_comb begin
    w_adj = w_sum;
    if (w_emitPos) begin
      w_adj = w_sum - P_ONE;
    end else if (w_emitNeg) begin
      w_adj = w_sum + P_ONE;
    end
    if (w_adj > P_MAX) begin
      w_next = P_MAX[W-1:0];
    end else if (w_adj < P_MIN) begin
      w_next = P_MIN[W-1:0];
    end else begin
      w_next = w_adj[W-1:0];
    end
  end

  // Count register: synchronous clear wins over accumulation.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_next;
    end
  end

endmodule

// File: rtl/nn_convnode_backprop.sv
// Backprop node for the stochastic convolution layer: weights the downstream
// error streams by their forward weights, collapses them through a signed
// difference counter, gates the result by the activation derivative and
// drains any residual count when the backprop phase ends.
module nn_convnode_backprop
  import nn_convnode_backprop_pkg::*;
#(
  parameter int N                  = 4,
  parameter int DIFFCOUNTER_SIZE   = 4,
  parameter int DIFFCOUNT_LOWERLIM = 1
) (
  input  logic         CLK,
  input  logic         INIT,
  input  logic         BP_EN,
  input  logic [N-1:0] delta_in,
  input  logic [N-1:0] SIGN_delta,
  input  logic [N-1:0] alpha,
  input  logic [N-1:0] SIGN_alpha,
  input  logic         zp,
  output logic         delta_out,
  output logic         SIGN_delta_out,
  output logic         BP_DONE
);

  localparam int CW  = cnt_width(N);
  // An illegal parameter set keeps the node permanently quiet instead of
  // producing wrapped, meaningless error streams.
  localparam bit P_OK = params_ok(N, DIFFCOUNTER_SIZE, DIFFCOUNT_LOWERLIM);

  logic [1:0]    r_state;
  logic [1:0]    w_nextState;
  logic          r_deltaOut;
  logic          r_signOut;
  logic          r_done;

  logic [N-1:0]  w_prod;
  logic [N-1:0]  w_prodSign;
  logic [CW-1:0] w_pos;
  logic [CW-1:0] w_neg;
  logic          w_countEn;
  logic          w_active;
  logic          w_clear;
  logic          w_emit;
  logic          w_emitSign;

  assign w_prod     = delta_in & alpha;
  assign w_prodSign = SIGN_delta ^ SIGN_alpha;
  assign w_countEn  = P_OK && (r_state == ST_RUN) && BP_EN;
  assign w_active   = P_OK && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
  assign w_clear    = (r_state == ST_IDLE);

  // Popcount of positive and negative weighted errors; zero outside active RUN.
  always_comb begin
    w_pos = '0;
    w_neg = '0;
    for (int i = 0; i < N; i++) begin
      if (w_countEn && w_prod[i] && !w_prodSign[i]) begin
        w_pos = w_pos + CW'(1);
      end
      if (w_countEn && w_prod[i] && w_prodSign[i]) begin
        w_neg = w_neg + CW'(1);
      end
    end
  end

  nn_sdiff_counter #(
    .W   (DIFFCOUNTER_SIZE),
    .CW  (CW),
    .LIM (DIFFCOUNT_LOWERLIM)
  ) u_counter (
    .i_clk      (CLK),
    .i_rst      (INIT),
    .i_clear    (w_clear),
    .i_en       (w_active),
    .i_pos      (w_pos),
    .i_neg      (w_neg),
    .o_emit     (w_emit),
    .o_emitSign (w_emitSign)
  );

  // Phase FSM: re-enabling during a drain resumes RUN with the count intact.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (BP_EN) w_nextState = ST_RUN;
      end
      ST_RUN: begin
        if (!BP_EN) w_nextState = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (BP_EN) begin
          w_nextState = ST_RUN;
        end else if (!w_emit) begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // State register and registered outputs; the sign only moves on an emit.
  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      r_state    <= ST_IDLE;
      r_deltaOut <= 1'b0;
      r_signOut  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_deltaOut <= w_emit & zp;
      if (w_emit) begin
        r_signOut <= w_emitSign;
      end
      r_done     <= (r_state == ST_DRAIN) && !BP_EN && !w_emit;
    end
  end

  assign delta_out      = r_deltaOut;
  assign SIGN_delta_out = r_signOut;
  assign BP_DONE        = r_done;

endmodule

// File: tb/tb_nn_convnode_backprop.sv
// Scoreboard bench for nn_convnode_backprop (N=4, W=4, L=1): a behavioural
// model predicts each cycle's registered outputs, the prediction is queued
// when the inputs are driven and compared after the following clock edge.
module tb_nn_convnode_backprop;

  localparam int N    = 4;
  localparam int W    = 4;
  localparam int L    = 1;
  localparam int DMAX = 7;
  localparam int DMIN = -8;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  typedef struct {
    logic out;
    logic sign;
    logic done;
  } expect_t;

  logic         CLK = 1'b0;
  logic         INIT;
  logic         BP_EN;
  logic [N-1:0] delta_in;
  logic [N-1:0] SIGN_delta;
  logic [N-1:0] alpha;
  logic [N-1:0] SIGN_alpha;
  logic         zp;
  logic         delta_out;
  logic         SIGN_delta_out;
  logic         BP_DONE;

  int      checkCount = 0;
  int      errorCount = 0;
  expect_t expQ[$];

  int   mState = M_IDLE;
  int   mD     = 0;
  logic mSign  = 1'b0;

  // 10 ns clock.
  always #5 CLK = ~CLK;

  nn_convnode_backprop #(
    .N                  (N),
    .DIFFCOUNTER_SIZE   (W),
    .DIFFCOUNT_LOWERLIM (L)
  ) dut (
    .CLK            (CLK),
    .INIT           (INIT),
    .BP_EN          (BP_EN),
    .delta_in       (delta_in),
    .SIGN_delta     (SIGN_delta),
    .alpha          (alpha),
    .SIGN_alpha     (SIGN_alpha),
    .zp             (zp),
    .delta_out      (delta_out),
    .SIGN_delta_out (SIGN_delta_out),
    .BP_DONE        (BP_DONE)
  );

  // Counts one comparison and reports it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference model: advances one clock and queues the outputs seen after the edge.
  task automatic modelStep(input logic bpEn, input logic [N-1:0] dIn, input logic [N-1:0] sD,
                           input logic [N-1:0] a, input logic [N-1:0] sA, input logic z);
    int      pos;
    int      neg;
    int      s;
    int      nd;
    logic    emit;
    logic    eSign;
    expect_t e;
    pos    = 0;
    neg    = 0;
    emit   = 1'b0;
    eSign  = 1'b0;
    e.done = 1'b0;
    if (mState == M_IDLE) begin
      mD     = 0;
      e.out  = 1'b0;
      e.sign = mSign;
      mState = bpEn ? M_RUN : M_IDLE;
    end else begin
      if (mState == M_RUN && bpEn) begin
        for (int i = 0; i < N; i++) begin
          if (dIn[i] && a[i]) begin
            if (sD[i] ^ sA[i]) neg++;
            else pos++;
          end
        end
      end
      s = mD + pos - neg;
      if (s >= L) begin
        emit = 1'b1; eSign = 1'b0; nd = s - 1;
      end else if (s <= -L) begin
        emit = 1'b1; eSign = 1'b1; nd = s + 1;
      end else begin
        nd = s;
      end
      if (nd > DMAX) nd = DMAX;
      if (nd < DMIN) nd = DMIN;
      mD = nd;
      if (emit) mSign = eSign;
      e.out  = emit & z;
      e.sign = mSign;
      if (mState == M_RUN) begin
        mState = bpEn ? M_RUN : M_DRAIN;
      end else if (bpEn) begin
        mState = M_RUN;
      end else if (!emit) begin
        mState = M_IDLE;
        e.done = 1'b1;
      end
    end
    expQ.push_back(e);
  endtask

  // Drives one cycle of inputs, predicts the result and checks it after the edge.
  task automatic applyStimulus(input string tag, input logic bpEn, input logic [N-1:0] dIn,
                               input logic [N-1:0] sD, input logic [N-1:0] a,
                               input logic [N-1:0] sA, input logic z);
    expect_t e;
    @(negedge CLK);
    BP_EN      = bpEn;
    delta_in   = dIn;
    SIGN_delta = sD;
    alpha      = a;
    SIGN_alpha = sA;
    zp         = z;
    modelStep(bpEn, dIn, sD, a, sA, z);
    @(posedge CLK);
    #1;
    if (expQ.size() == 0) begin
      checkOutput({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = expQ.pop_front();
      checkOutput({tag, "_out"},  delta_out,      e.out);
      checkOutput({tag, "_sign"}, SIGN_delta_out, e.sign);
      checkOutput({tag, "_done"}, BP_DONE,        e.done);
    end
  endtask

  // Asserts INIT between clock edges and checks the outputs clear without a clock.
  task automatic applyReset(input string tag);
    @(negedge CLK);
    BP_EN = 1'b0;
    INIT  = 1'b1;
    #1;
    checkOutput({tag, "_rst_out"},  delta_out,      32'd0);
    checkOutput({tag, "_rst_sign"}, SIGN_delta_out, 32'd0);
    checkOutput({tag, "_rst_done"}, BP_DONE,        32'd0);
    mState = M_IDLE;
    mD     = 0;
    mSign  = 1'b0;
    expQ.delete();
    @(posedge CLK);
    #1;
    @(negedge CLK);
    INIT = 1'b0;
  endtask

  // Bounds the run in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    INIT       = 1'b1;
    BP_EN      = 1'b0;
    delta_in   = '0;
    SIGN_delta = '0;
    alpha      = '0;
    SIGN_alpha = '0;
    zp         = 1'b0;

    $display("[TB] reset state");
    applyReset("boot");

    $display("[TB] positive accumulation with saturation");
    applyStimulus("s1_enter", 1'b1, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1);
    repeat (3) applyStimulus("s1_run", 1'b1, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1);

    $display("[TB] drain from full count");
    repeat (10) applyStimulus("s4_drain", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);

    $display("[TB] negative accumulation");
    applyStimulus("s2_enter", 1'b1, 4'b0011, 4'b0000, 4'b0011, 4'b0011, 1'b1);
    repeat (3) applyStimulus("s2_run", 1'b1, 4'b0011, 4'b0000, 4'b0011, 4'b0011, 1'b1);
    repeat (6) applyStimulus("s2_drain", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);

    $display("[TB] cancellation holds sign");
    applyStimulus("s3_enter", 1'b1, 4'hF, 4'b0101, 4'hF, 4'h0, 1'b1);
    repeat (3) applyStimulus("s3_run", 1'b1, 4'hF, 4'b0101, 4'hF, 4'h0, 1'b1);

    $display("[TB] derivative gating");
    repeat (3) applyStimulus("s5_run", 1'b1, 4'hF, 4'h0, 4'hF, 4'h0, 1'b0);
    repeat (10) applyStimulus("s5_drain", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    $display("[TB] reset during drain");
    applyStimulus("s6_enter", 1'b1, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1);
    repeat (3) applyStimulus("s6_run", 1'b1, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1);
    repeat (3) applyStimulus("s6_drain", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
    applyReset("s6");
    repeat (4) applyStimulus("s6_post", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
    applyStimulus("s6_restart", 1'b1, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1);
    repeat (2) applyStimulus("s6_rerun", 1'b1, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1);

    $display("[TB] toggling enable with random streams");
    for (int k = 0; k < 40; k++) begin
      applyStimulus("tog", k[0] ? 1'b0 : 1'b1, 4'($urandom), 4'($urandom),
                    4'($urandom), 4'($urandom), 1'($urandom));
    end
    repeat (12) applyStimulus("tog_drain", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
